// File: rtl/adc_conv_ctrl.sv
// Conversion sequencer for a 4-bit flash ADC: track/hold and latch timing,
// per-conversion averaging of encoder codes and thermometer bubble detection.
module adc_conv_ctrl #(
  parameter int unsigned TRACK_CYC  = 4,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned AVG_LOG2   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [14:0] therm_in,
  input  logic [3:0]  code_in,
  output logic        sh_track,
  output logic        cmp_latch,
  output logic        busy,
  output logic        done,
  output logic [3:0]  data_out,
  output logic        err
);

  localparam int unsigned ACC_W = 4 + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [7:0] TRACK_LAST  = 8'(TRACK_CYC - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRACK,
    S_SETTLE,
    S_LATCH,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t             state, state_next;
  logic [7:0]         tmr;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_sum;
  logic [ACC_W-1:0]   avg;
  logic [CNT_W-1:0]   cnt;
  logic               err_int;
  logic               bubble;
  logic               last_sample;

  // A legal thermometer word plus one is a power of two, so it shares no set bit with itself.
  assign bubble      = |(therm_in & (therm_in + 15'd1));
  assign acc_sum     = acc + ACC_W'(code_in);
  assign avg         = acc_sum >> AVG_LOG2;
  assign last_sample = (cnt == LAST_SAMPLE);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    state_next = state;
    sh_track   = 1'b0;
    cmp_latch  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !abort) state_next = S_TRACK;
      end
      S_TRACK: begin
        sh_track = 1'b1;
        busy     = 1'b1;
        if (abort)                    state_next = S_IDLE;
        else if (tmr == TRACK_LAST)   state_next = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (abort)                    state_next = S_IDLE;
        else if (tmr == SETTLE_LAST)  state_next = S_LATCH;
      end
      S_LATCH: begin
        cmp_latch = 1'b1;
        busy      = 1'b1;
        state_next = abort ? S_IDLE : S_CAPTURE;
      end
      S_CAPTURE: begin
        busy = 1'b1;
        if (abort)            state_next = S_IDLE;
        else if (last_sample) state_next = S_DONE;
        else                  state_next = S_TRACK;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tmr      <= '0;
      acc      <= '0;
      cnt      <= '0;
      err_int  <= 1'b0;
      data_out <= '0;
      err      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      state <= state_next;
      tmr   <= (state_next != state) ? 8'd0 : tmr + 8'd1;
      if (state == S_IDLE && start && !abort) begin
        acc     <= '0;
        cnt     <= '0;
        err_int <= 1'b0;
      end
      if (state == S_CAPTURE && !abort) begin
        acc     <= acc_sum;
        cnt     <= cnt + 1'b1;
        err_int <= err_int | bubble;
        // Result registers load on the final capture so they are valid during the DONE cycle.
        if (last_sample) begin
          data_out <= avg[3:0];
          err      <= err_int | bubble;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_conv_ctrl.sv
// Directed bench: default-parameter instance for the main sequence,
// a short single-sample instance for minimum timing and mid-conversion reset.
module tb_adc_conv_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b1, start0 = 1'b0, abort0 = 1'b0;
  logic [14:0] therm0 = '0;
  logic [3:0]  code0 = '0;
  logic        sh0, lat0, busy0, done0, err0;
  logic [3:0]  data0;

  logic        rst1 = 1'b1, start1 = 1'b0, abort1 = 1'b0;
  logic [14:0] therm1 = '0;
  logic [3:0]  code1 = '0;
  logic        sh1, lat1, busy1, done1, err1;
  logic [3:0]  data1;

  int n_cmp = 0;
  int n_bad = 0;

  adc_conv_ctrl dut0 (
    .clk(clk), .rst(rst0), .start(start0), .abort(abort0),
    .therm_in(therm0), .code_in(code0),
    .sh_track(sh0), .cmp_latch(lat0), .busy(busy0), .done(done0),
    .data_out(data0), .err(err0)
  );

  adc_conv_ctrl #(.TRACK_CYC(1), .SETTLE_CYC(1), .AVG_LOG2(0)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .abort(abort1),
    .therm_in(therm1), .code_in(code1),
    .sh_track(sh1), .cmp_latch(lat1), .busy(busy1), .done(done1),
    .data_out(data1), .err(err1)
  );

  // Drives one conversion on dut0 starting in the current cycle (cycle 0) and
  // records what the outputs did over the following 45 cycles.
  task automatic run_conv(
    input  logic [15:0] codes,
    input  logic [59:0] therms,
    input  int          abort_at,
    input  int          pulse_a,
    input  int          pulse_b,
    output int          done_cnt,
    output int          done_cyc,
    output int          latches,
    output int          busy_first,
    output int          busy_last,
    output logic [3:0]  dval,
    output logic        eval
  );
    int s;
    done_cnt = 0; done_cyc = -1; latches = 0;
    busy_first = -1; busy_last = -1; dval = 'x; eval = 1'bx;
    code0  = codes[3:0];
    therm0 = therms[14:0];
    abort0 = 1'b0;
    start0 = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      start0 = (k == pulse_a) || (k == pulse_b);
      abort0 = (k == abort_at);
      s = (k - 1) / 8;
      if (s > 3) s = 3;
      code0  = codes[4*s +: 4];
      therm0 = therms[15*s +: 15];
      if (busy0) begin
        if (busy_first < 0) busy_first = k;
        busy_last = k;
      end
      if (lat0) latches++;
      if (done0) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
        dval = data0;
        eval = err0;
      end
    end
    start0 = 1'b0;
    abort0 = 1'b0;
  endtask

  localparam logic [59:0] CLEAN = {4{15'h01FF}};

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({sh0, lat0, busy0, done0, data0, err0} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 0", {sh0, lat0, busy0, done0, data0, err0});
    end
    rst0 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int dc, dcyc, lt, bf, bl;
    logic [3:0] d;
    logic e;
    run_conv(16'h9999, CLEAN, -1, -1, -1, dc, dcyc, lt, bf, bl, d, e);
    n_cmp++; if (dcyc !== 33) begin n_bad++; $display("FAIL basic_done_cycle: got %0d want 33", dcyc); end
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", dc); end
    n_cmp++; if (d !== 4'd9) begin n_bad++; $display("FAIL basic_data: got %0d want 9", d); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b want 0", e); end
    n_cmp++; if (bf !== 1 || bl !== 32) begin n_bad++; $display("FAIL basic_busy_window: got %0d..%0d want 1..32", bf, bl); end
    n_cmp++; if (lt !== 4) begin n_bad++; $display("FAIL basic_latch_pulses: got %0d want 4", lt); end
    n_cmp++; if (data0 !== 4'd9) begin n_bad++; $display("FAIL basic_data_held: got %0d want 9", data0); end
  endtask

  task automatic test_truncation;
    int dc, dcyc, lt, bf, bl;
    logic [3:0] d;
    logic e;
    run_conv(16'h6443, CLEAN, -1, -1, -1, dc, dcyc, lt, bf, bl, d, e);
    n_cmp++; if (d !== 4'd4) begin n_bad++; $display("FAIL trunc_data: got %0d want 4", d); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL trunc_err: got %b want 0", e); end
  endtask

  task automatic test_bubble;
    int dc, dcyc, lt, bf, bl;
    logic [3:0] d;
    logic e;
    run_conv(16'h5555, {15'h01FF, 15'h01FF, 15'h0005, 15'h01FF}, -1, -1, -1,
             dc, dcyc, lt, bf, bl, d, e);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL bubble_err: got %b want 1", e); end
    n_cmp++; if (d !== 4'd5) begin n_bad++; $display("FAIL bubble_data: got %0d want 5", d); end
    n_cmp++; if (err0 !== 1'b1) begin n_bad++; $display("FAIL bubble_err_held: got %b want 1", err0); end
    run_conv(16'h7777, CLEAN, -1, -1, -1, dc, dcyc, lt, bf, bl, d, e);
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL bubble_clear: got %b want 0", e); end
    n_cmp++; if (d !== 4'd7) begin n_bad++; $display("FAIL bubble_clean_data: got %0d want 7", d); end
  endtask

  task automatic test_abort;
    int dc, dcyc, lt, bf, bl;
    logic [3:0] d;
    logic e;
    run_conv(16'h3333, CLEAN, 21, -1, -1, dc, dcyc, lt, bf, bl, d, e);
    n_cmp++; if (dc !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", dc); end
    n_cmp++; if (bl !== 21) begin n_bad++; $display("FAIL abort_busy_last: got %0d want 21", bl); end
    n_cmp++; if (lt !== 2) begin n_bad++; $display("FAIL abort_latches: got %0d want 2", lt); end
    n_cmp++; if (data0 !== 4'd7 || err0 !== 1'b0) begin n_bad++; $display("FAIL abort_data_kept: got %0d/%b want 7/0", data0, err0); end
    run_conv(16'h9999, CLEAN, -1, -1, -1, dc, dcyc, lt, bf, bl, d, e);
    n_cmp++; if (dcyc !== 33 || d !== 4'd9) begin n_bad++; $display("FAIL abort_restart: got cyc %0d data %0d want 33/9", dcyc, d); end
  endtask

  task automatic test_back_to_back;
    int dc, dcyc, lt, bf, bl;
    logic [3:0] d;
    logic e;
    run_conv(16'hCCCC, CLEAN, -1, 10, 33, dc, dcyc, lt, bf, bl, d, e);
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 1", dc); end
    n_cmp++; if (dcyc !== 33) begin n_bad++; $display("FAIL b2b_done_cycle: got %0d want 33", dcyc); end
    n_cmp++; if (bl !== 32) begin n_bad++; $display("FAIL b2b_busy_last: got %0d want 32", bl); end
    n_cmp++; if (d !== 4'd12) begin n_bad++; $display("FAIL b2b_data: got %0d want 12", d); end
  endtask

  task automatic test_min_config;
    int dcyc;
    dcyc = -1;
    rst1 = 1'b0;
    therm1 = 15'h7FFF;
    code1 = 4'd15;
    @(posedge clk); #1;
    start1 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      if (done1 && dcyc < 0) dcyc = k;
    end
    n_cmp++; if (dcyc !== 5) begin n_bad++; $display("FAIL min_done_cycle: got %0d want 5", dcyc); end
    n_cmp++; if (data1 !== 4'd15 || err1 !== 1'b0) begin n_bad++; $display("FAIL min_data: got %0d/%b want 15/0", data1, err1); end
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n_cmp++; if (sh1 !== 1'b1) begin n_bad++; $display("FAIL min_track: got %b want 1", sh1); end
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    n_cmp++;
    if ({sh1, lat1, busy1, done1, data1, err1} !== 9'd0) begin
      n_bad++;
      $display("FAIL min_mid_reset: got %b want 0", {sh1, lat1, busy1, done1, data1, err1});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_truncation();
    test_bubble();
    test_abort();
    test_back_to_back();
    test_min_config();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
